// File: rtl/gray_pkg.sv
// Shared Gray-code helpers so the encoder side and every decoder agree on the
// code width and on how a Gray word maps back to binary.
package gray_pkg;

    localparam int GRAY_WIDTH = 4;
    // Helpers work on a fixed wide word; callers zero-extend and truncate.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [5:0] popcount(input logic [GRAY_MAX_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic multi-flop synchroniser for bringing a bus across a clock boundary.
// Only safe for buses where at most one bit changes at a time (e.g. Gray codes).
module sync_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/gray_bin_rx.sv
// Receive-side Gray decoder: synchronises a foreign Gray bus, decodes it to
// binary, reports the step between samples and counts illegal multi-bit jumps.
module gray_bin_rx
    import gray_pkg::*;
#(
    parameter int WIDTH       = GRAY_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     G_in,
    input  logic                 en,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     B,
    output logic                 valid,
    output logic [WIDTH-1:0]     step,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    logic [WIDTH-1:0] g_sync;
    logic [WIDTH-1:0] g_prev;
    logic [WIDTH-1:0] b;
    logic [5:0]       flips;
    logic             resync;
    logic             err_next;

    sync_chain #(
        .WIDTH (WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (G_in),
        .q     (g_sync)
    );

    assign b     = WIDTH'(gray2bin(GRAY_MAX_W'(g_sync)));
    assign flips = popcount(GRAY_MAX_W'(g_sync ^ g_prev));

    // The first sample after a disabled stretch may legitimately have moved by
    // many codes, so it is not treated as an illegal jump.
    assign err_next = en && !resync && (flips > 6'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_prev <= '0;
            B      <= '0;
            valid  <= 1'b0;
            step   <= '0;
            err    <= 1'b0;
            resync <= 1'b0;
        end else if (en) begin
            g_prev <= g_sync;
            B      <= b;
            valid  <= (g_sync != g_prev);
            step   <= b - B;
            err    <= err_next;
            resync <= 1'b0;
        end else begin
            valid  <= 1'b0;
            err    <= 1'b0;
            resync <= 1'b1;
        end
    end

    // A clear that lands on an error still records that error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= err_next ? CNT_ONE : '0;
        end else if (err_next && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_ONE;
        end
    end

endmodule

// File: doc/gray_bin_rx.md
# gray_bin_rx

Receive-side Gray-code decoder for counters and pointers encoded by the team's binary-to-Gray encoder. It synchronises a Gray-coded bus arriving from an unrelated source into the local clock and decodes it to binary through a registered stage. It also reports the signed step between successive samples and flags illegal multi-bit transitions. It sits at the consumer end of any Gray-coded pointer or position link.

## Interface

Parameters:
- WIDTH, 4, code width in bits (≥2)
- SYNC_STAGES, 2, synchroniser flops on G_in (≥2)
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- G_in  in  WIDTH  Gray-coded input; asynchronous to clk
- en  in  1  decode enable
- clr_err  in  1  synchronous clear of err_cnt
- B  out  WIDTH  decoded binary value, registered
- valid  out  1  one-cycle pulse; B changed this cycle
- step  out  WIDTH  (B_new − B_old) mod 2^WIDTH; meaningful only while valid=1
- err  out  1  one-cycle pulse; synced sample differs from previous in more than one bit
- err_cnt  out  ERR_CNT_W  saturating count of err pulses

## Operation

- Synchroniser:
  - SYNC_STAGES-deep flop chain on G_in, yielding g_sync.
  - The chain always runs, regardless of en.
- Decode:
  - b[WIDTH-1] = g_sync[WIDTH-1].
  - b[i] = b[i+1] ^ g_sync[i] for i = WIDTH-2 down to 0.
- Compare register g_prev holds the last accepted Gray sample.
- Each cycle with en=1:
  - g_prev ← g_sync.
  - B ← b.
  - valid = (g_sync ≠ g_prev).
  - step = b − B (old B, modulo 2^WIDTH).
  - err = popcount(g_sync ^ g_prev) > 1, and not suppressed.
- en=0:
  - B, g_prev, step hold.
  - valid=0, err=0.
- Re-enable:
  - Internal flag resync is set while en=0.
  - On the first en=1 cycle after en=0, err is suppressed and resync clears.
  - valid and B still update normally on that cycle.
- Wrap-around: all-ones binary to zero is a single Gray-bit change. It yields valid=1, step=1, err=0.
- Illegal jump:
  - err pulses and err_cnt increments.
  - B still takes the decoded value, so the decoder never stalls.
- err_cnt:
  - Saturates at 2^ERR_CNT_W − 1.
  - clr_err alone clears it to 0.
  - clr_err coinciding with an err pulse gives err_cnt = 1; no event is lost.

## Timing

- All outputs reset to 0 asynchronously on rst_n low. This covers B, valid, step, err and err_cnt.
- Synchroniser flops, g_prev and resync also reset to 0.
- Reset mid-operation discards all in-flight samples. After release, the first comparison is against g_prev = 0.
- Latency: a G_in change stable before edge n is visible on B/valid/step/err after edge n + SYNC_STAGES. That is SYNC_STAGES + 1 registered stages, i.e. 3 cycles at the defaults.
- valid and err are single-cycle pulses. A steady G_in produces no further pulses.
- Back-to-back G_in changes one cycle apart produce back-to-back valid pulses; there is no gap or loss.
- Throughput is one sample per cycle.

## Structure

- Shared package gray_pkg holds:
  - function gray2bin(WIDTH), the iterative XOR chain.
  - function popcount.
  - the default WIDTH constant, so the encoder side and this block agree.
- One sub-module, sync_chain, is parameterised on width and depth and is reused elsewhere for CDC.
- Decode, compare and error-count logic live in gray_bin_rx.

## Test plan

1. **Reset:**
   - Stimulus: rst_n low with G_in=1011, then release with G_in=0000.
   - Required: all outputs 0 throughout, and no valid or err pulse afterwards.
2. **Legal decode sequence:**
   - Stimulus: G_in 1000 → 1001 → 1011, each held 5 cycles.
   - Required: B = 1111, 1110, 1101 respectively, each 3 cycles after its change.
   - After the first change (0000 → 1000): valid=1, step=1111.
   - After each later change: valid=1, step=1111, err=0.
3. **Wrap:**
   - Stimulus: G_in 1000 → 0000.
   - Required: B=0000, valid=1, step=0001, err=0.
4. **Illegal jump:**
   - Stimulus: G_in 0000 → 0011.
   - Required: B=0010, valid=1, step=0010, err=1, err_cnt=1.
   - Then drive 300 alternating 0000/0011 changes.
   - Required: err_cnt saturates at 255.
5. **Clear collision:**
   - Stimulus: assert clr_err on the same cycle as an err pulse.
   - Required: err_cnt=1 next cycle.
   - Then assert clr_err alone.
   - Required: err_cnt=0.
6. **Enable gating:**
   - Stimulus: en=0, G_in 0000 → 0110; then en=1.
   - Required while en=0: B holds 0000, with no valid or err.
   - Required on re-enable: B=0100, valid=1, step=0100, err=0.
